mem_pipe_reg: RTL and testbench
===============================

Name: mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline register for the 5-stage core.
- Replaces the fixed clear/block stage register with a valid/ready handshake and an optional 2-entry skid buffer.
- Carries destination register, ALU result and an encoded load type.
- Produces load-use hazard flags for two source-register queries from the decode stage.

Parameters:
- DATA_W, 32, width of ALU result payload.
- RD_W, 5, width of register index.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of all entries (branch mispredict / trap).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_rd  in  RD_W  destination register.
- in_data  in  DATA_W  ALU result / effective address.
- in_ld_type  in  3  load type: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu; 6 and 7 are treated as none.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_rd  out  RD_W  head destination register.
- out_data  out  DATA_W  head payload.
- out_ld_type  out  3  head load type; always 0 when out_valid = 0.
- out_load  out  1  out_valid && head load type in 1..5.
- occupancy  out  2  entries held (0..2; max 1 when SKID = 0).
- q_rs1, q_rs2  in  RD_W  decode-stage source registers.
- haz_rs1, haz_rs2  out  1  load-use hazard flags.

Behaviour:
- Reset (rst = 1 at an edge): both entries invalid; out_rd, out_data, out_ld_type, out_load, out_valid, occupancy all 0.
  - in_ready = 0 while rst is high.
  - in_ready = 1 in the first cycle after rst deasserts.
- Transfers:
  - Input accept = in_valid && in_ready.
  - Output pop = out_valid && out_ready.
  - Latency: an accepted entry appears on out_* the next cycle when the stage was empty (or became empty by a same-cycle pop).
- SKID = 1 (entries HEAD and SKB):
  - in_ready = !SKB.valid, registered, with no combinational path from out_ready.
  - Accept with HEAD empty, or HEAD popping while SKB is empty: the entry loads HEAD.
  - Accept with HEAD full and not popping: the entry loads SKB.
  - Pop with SKB full: SKB moves to HEAD and SKB clears. No accept is possible that cycle because in_ready = 0.
  - Order is strictly FIFO; no entry is lost or duplicated.
- SKID = 0 (single register): in_ready = !out_valid || out_ready. Accept and pop in the same cycle replaces HEAD.
- Flush: at the edge, all entries become invalid and payloads are zeroed.
  - Flush has priority over accept and pop; an entry accepted in the flush cycle is discarded.
  - rst has priority over flush.
- Held entries keep their payload unchanged while out_ready = 0.
- Invalid entries present 0 on out_rd, out_data and out_ld_type.
- Hazard flags: haz_rsN = (out_load && out_rd == q_rsN && q_rsN != 0) || (SKB.valid && SKB is a load && SKB.rd == q_rsN && q_rsN != 0).
  - Combinational from state and q_rsN.
  - A load to x0 never raises a hazard.
- occupancy = HEAD.valid + SKB.valid.
- Load types 6 and 7 are stored as 0 (none).

Test Plan:
- Reset, then in_valid = 1 with rd = 5, data = 0x1234_5678, ld_type = 3, out_ready = 1 → next cycle out_valid = 1, out_rd = 5, out_data = 0x12345678, out_load = 1, occupancy = 1.
- SKID = 1, out_ready = 0, push A (rd 1) then B (rd 2) → occupancy = 2, in_ready = 0; raise out_ready → A, then B on consecutive cycles, in_ready returns to 1 after B's move.
- Flush while occupancy = 2 and in_valid = 1 → next cycle out_valid = 0, occupancy = 0, all out_* = 0; the flush-cycle input never appears.
- Head is an lbu to rd = 7, q_rs1 = 7, q_rs2 = 0 → haz_rs1 = 1, haz_rs2 = 0. Same with ld_type = 0 → both 0. Load to rd = 0 with q_rs1 = 0 → 0.
- SKID = 0, continuous in_valid with out_ready = 1 for 8 cycles, data 0..7 → out_data 0..7 in order, one per cycle; drop out_ready for one cycle → in_ready = 0 that cycle, no loss.
- rst asserted mid-stream with occupancy = 2 → next cycle all outputs 0, in_ready = 0 until rst drops; in_ld_type = 6 pushed afterwards → out_ld_type = 0, out_load = 0.

Source files
------------

// File: rtl/mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, and load-use hazard detection for two decode-stage source queries.
module mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_ld_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_ld_type,
    output logic              out_load,
    output logic [1:0]        occupancy,
    input  logic [RD_W-1:0]   q_rs1,
    input  logic [RD_W-1:0]   q_rs2,
    output logic              haz_rs1,
    output logic              haz_rs2
);

    function automatic logic [2:0] sanitize_ld(input logic [2:0] t);
        return (t > 3'd5) ? 3'd0 : t;
    endfunction

    function automatic logic is_load(input logic [2:0] t);
        return (t != 3'd0) && (t <= 3'd5);
    endfunction

    // Head entry (_p0) and skid entry (_p1) state
    logic              vld_p0, vld_p1;
    logic [RD_W-1:0]   rd_p0, rd_p1;
    logic [DATA_W-1:0] data_p0, data_p1;
    logic [2:0]        ld_p0, ld_p1;
    logic              ready_r;

    logic              vld_p0_n, vld_p1_n;
    logic [RD_W-1:0]   rd_p0_n, rd_p1_n;
    logic [DATA_W-1:0] data_p0_n, data_p1_n;
    logic [2:0]        ld_p0_n, ld_p1_n;

    logic accept, pop;

    assign in_ready = (SKID != 0) ? (ready_r && !rst) : (!rst && (!vld_p0 || out_ready));
    assign accept   = in_valid && in_ready;
    assign pop      = vld_p0 && out_ready;

    always_comb begin
        vld_p0_n  = vld_p0;
        rd_p0_n   = rd_p0;
        data_p0_n = data_p0;
        ld_p0_n   = ld_p0;
        vld_p1_n  = vld_p1;
        rd_p1_n   = rd_p1;
        data_p1_n = data_p1;
        ld_p1_n   = ld_p1;
        if (SKID != 0) begin
            if (vld_p1) begin
                // in_ready is low whenever the skid entry is full, so only a move can happen
                if (pop) begin
                    vld_p0_n  = 1'b1;
                    rd_p0_n   = rd_p1;
                    data_p0_n = data_p1;
                    ld_p0_n   = ld_p1;
                    vld_p1_n  = 1'b0;
                    rd_p1_n   = '0;
                    data_p1_n = '0;
                    ld_p1_n   = '0;
                end
            end else if (accept) begin
                if (!vld_p0 || pop) begin
                    vld_p0_n  = 1'b1;
                    rd_p0_n   = in_rd;
                    data_p0_n = in_data;
                    ld_p0_n   = sanitize_ld(in_ld_type);
                end else begin
                    vld_p1_n  = 1'b1;
                    rd_p1_n   = in_rd;
                    data_p1_n = in_data;
                    ld_p1_n   = sanitize_ld(in_ld_type);
                end
            end else if (pop) begin
                vld_p0_n = 1'b0;
            end
        end else begin
            if (accept) begin
                vld_p0_n  = 1'b1;
                rd_p0_n   = in_rd;
                data_p0_n = in_data;
                ld_p0_n   = sanitize_ld(in_ld_type);
            end else if (pop) begin
                vld_p0_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p0  <= 1'b0;
            rd_p0   <= '0;
            data_p0 <= '0;
            ld_p0   <= '0;
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
            ld_p1   <= '0;
            ready_r <= 1'b1;
        end else begin
            vld_p0  <= vld_p0_n;
            rd_p0   <= rd_p0_n;
            data_p0 <= data_p0_n;
            ld_p0   <= ld_p0_n;
            vld_p1  <= vld_p1_n;
            rd_p1   <= rd_p1_n;
            data_p1 <= data_p1_n;
            ld_p1   <= ld_p1_n;
            ready_r <= !vld_p1_n;
        end
    end

    assign out_valid   = vld_p0;
    assign out_rd      = vld_p0 ? rd_p0 : '0;
    assign out_data    = vld_p0 ? data_p0 : '0;
    assign out_ld_type = vld_p0 ? ld_p0 : 3'd0;
    assign out_load    = vld_p0 && is_load(ld_p0);
    assign occupancy   = {1'b0, vld_p0} + {1'b0, vld_p1};

    // A load targeting x0 never blocks decode, hence the q_rsN != 0 guard
    assign haz_rs1 = (q_rs1 != '0) &&
                     ((out_load && (rd_p0 == q_rs1)) ||
                      (vld_p1 && is_load(ld_p1) && (rd_p1 == q_rs1)));
    assign haz_rs2 = (q_rs2 != '0) &&
                     ((out_load && (rd_p0 == q_rs2)) ||
                      (vld_p1 && is_load(ld_p1) && (rd_p1 == q_rs2)));

endmodule

// File: tb/tb_mem_pipe_reg.sv
// Bench for mem_pipe_reg: a SKID=1 and a SKID=0 instance share stimulus and are
// each compared against a queue-based FIFO reference model every cycle.
module tb_mem_pipe_reg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  ld;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [4:0]  in_rd, q_rs1, q_rs2;
    logic [31:0] in_data;
    logic [2:0]  in_ld_type;

    logic        ir1, ov1, ol1, h11, h21;
    logic [4:0]  ord1;
    logic [31:0] od1;
    logic [2:0]  olt1;
    logic [1:0]  occ1;
    logic        ir0, ov0, ol0, h10, h20;
    logic [4:0]  ord0;
    logic [31:0] od0;
    logic [2:0]  olt0;
    logic [1:0]  occ0;

    ent_t q1[$];
    ent_t q0[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_pipe_reg #(.DATA_W(32), .RD_W(5), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_rd(in_rd), .in_data(in_data), .in_ld_type(in_ld_type),
        .out_valid(ov1), .out_ready(out_ready), .out_rd(ord1), .out_data(od1),
        .out_ld_type(olt1), .out_load(ol1), .occupancy(occ1),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .haz_rs1(h11), .haz_rs2(h21)
    );

    mem_pipe_reg #(.DATA_W(32), .RD_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_rd(in_rd), .in_data(in_data), .in_ld_type(in_ld_type),
        .out_valid(ov0), .out_ready(out_ready), .out_rd(ord0), .out_data(od0),
        .out_ld_type(olt0), .out_load(ol0), .occupancy(occ0),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .haz_rs1(h10), .haz_rs2(h20)
    );

    function automatic logic ld_is_load(input logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected in_ready from the model's point of view
    function automatic logic model_ready(input int skid);
        if (rst) return 1'b0;
        if (skid != 0) return (q1.size() < 2);
        return (q0.size() == 0) || out_ready;
    endfunction

    task automatic check_dut(input string n, input int skid,
                             input logic ir, input logic ov, input logic [4:0] ord,
                             input logic [31:0] od, input logic [2:0] olt, input logic ol,
                             input logic [1:0] occ, input logic h1, input logic h2);
        ent_t q[$];
        logic e1, e2;
        if (skid != 0) q = q1; else q = q0;
        e1 = 1'b0;
        e2 = 1'b0;
        foreach (q[i]) begin
            if (ld_is_load(q[i].ld) && q[i].rd == q_rs1 && q_rs1 != 0) e1 = 1'b1;
            if (ld_is_load(q[i].ld) && q[i].rd == q_rs2 && q_rs2 != 0) e2 = 1'b1;
        end
        check({n, ".in_ready"},    32'(ir),  32'(model_ready(skid)));
        check({n, ".out_valid"},   32'(ov),  32'(q.size() > 0));
        check({n, ".out_rd"},      32'(ord), (q.size() > 0) ? 32'(q[0].rd) : 32'd0);
        check({n, ".out_data"},    od,       (q.size() > 0) ? q[0].data : 32'd0);
        check({n, ".out_ld_type"}, 32'(olt), (q.size() > 0) ? 32'(q[0].ld) : 32'd0);
        check({n, ".out_load"},    32'(ol),  32'((q.size() > 0) && ld_is_load(q[0].ld)));
        check({n, ".occupancy"},   32'(occ), 32'(q.size()));
        check({n, ".haz_rs1"},     32'(h1),  32'(e1));
        check({n, ".haz_rs2"},     32'(h2),  32'(e2));
    endtask

    task automatic step(input logic iv, input logic [4:0] rd, input logic [31:0] d,
                        input logic [2:0] lt, input logic ordy, input logic fl,
                        input logic r, input logic [4:0] a, input logic [4:0] b);
        logic acc1, pop1, acc0, pop0;
        ent_t e;
        in_valid = iv; in_rd = rd; in_data = d; in_ld_type = lt;
        out_ready = ordy; flush = fl; rst = r; q_rs1 = a; q_rs2 = b;
        #1;
        check_dut("skid1", 1, ir1, ov1, ord1, od1, olt1, ol1, occ1, h11, h21);
        check_dut("skid0", 0, ir0, ov0, ord0, od0, olt0, ol0, occ0, h10, h20);
        acc1 = iv && model_ready(1);
        acc0 = iv && model_ready(0);
        pop1 = (q1.size() > 0) && ordy;
        pop0 = (q0.size() > 0) && ordy;
        e.rd = rd; e.data = d; e.ld = (lt > 3'd5) ? 3'd0 : lt;
        @(posedge clk);
        if (r || fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (pop0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 32'd0, 3'd0, ordy, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rd = '0; in_data = '0; in_ld_type = '0; q_rs1 = '0; q_rs2 = '0;
        @(posedge clk);
        @(negedge clk);
        q1.delete();
        q0.delete();

        // Reset state and first-cycle-after-reset ready
        step(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd5, 32'h1234_5678, 3'd3, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
        idle(1'b0);
        idle(1'b1);

        // Fill skid with A then B, then drain
        step(1'b1, 5'd1, 32'hA, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'hB, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush at occupancy 2 with a live input
        step(1'b1, 5'd3, 32'hC, 3'd1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd4, 32'hD, 3'd2, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd9, 32'hEE, 3'd3, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(1'b1);
        idle(1'b1);

        // Hazard queries: lbu to x7, non-load to x7, load to x0
        step(1'b1, 5'd7, 32'h70, 3'd4, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'h71, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd0, 32'h72, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(1'b1);

        // Streaming 0..7, then a one-cycle stall
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i + 1), 32'(i), 3'd3, 1'b1, 1'b0, 1'b0, 5'(i), 5'd0);
        step(1'b1, 5'd9, 32'd8, 3'd3, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0);
        step(1'b1, 5'd10, 32'd9, 3'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd10);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stream at occupancy 2, then an ld_type 6 push
        step(1'b1, 5'd11, 32'h11, 3'd1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd12, 32'h12, 3'd5, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd13, 32'h13, 3'd5, 1'b0, 1'b0, 1'b1, 5'd12, 5'd11);
        step(1'b1, 5'd13, 32'h13, 3'd5, 1'b1, 1'b0, 1'b1, 5'd13, 5'd0);
        step(1'b1, 5'd14, 32'h14, 3'd6, 1'b1, 1'b0, 1'b0, 5'd14, 5'd0);
        step(1'b1, 5'd15, 32'h15, 3'd7, 1'b0, 1'b0, 1'b0, 5'd14, 5'd15);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 79) == 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
